// File: rtl/mac_operand_feeder_if.sv
// rtl/mac_operand_feeder_if.sv - buffer read and MAC drive bus between the feeder and one MAC lane
interface mac_operand_feeder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] in_rdata;
  logic [DATA_W-1:0] w_rdata;
  logic              mac_clear;
  logic              mac_enable;
  logic [DATA_W-1:0] mac_in_data;
  logic [DATA_W-1:0] mac_weight;
  logic [DATA_W-1:0] mac_out;

  modport master (
    output rd_en, in_addr, w_addr, mac_clear, mac_enable, mac_in_data, mac_weight,
    input  in_rdata, w_rdata, mac_out
  );

  modport slave (
    input  rd_en, in_addr, w_addr, mac_clear, mac_enable, mac_in_data, mac_weight,
    output in_rdata, w_rdata, mac_out
  );
endinterface

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - clears a Q8.8 MAC, streams len operand pairs into it and captures the sum
module mac_operand_feeder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic [ADDR_W-1:0]   in_base,
  input  logic [ADDR_W-1:0]   w_base,
  output logic                busy,
  output logic [DATA_W-1:0]   result,
  output logic                done,
  mac_operand_feeder_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] in_base_q;
  logic [ADDR_W-1:0] w_base_q;

  // Buffer read data lines up with mac_enable, so operands pass straight through.
  assign bus.mac_in_data = bus.in_rdata;
  assign bus.mac_weight  = bus.w_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      len_q          <= '0;
      cnt            <= '0;
      in_base_q      <= '0;
      w_base_q       <= '0;
      busy           <= 1'b0;
      result         <= '0;
      done           <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.in_addr    <= '0;
      bus.w_addr     <= '0;
      bus.mac_clear  <= 1'b0;
      bus.mac_enable <= 1'b0;
    end else begin
      done           <= 1'b0;
      bus.mac_clear  <= 1'b0;
      bus.mac_enable <= bus.rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q         <= len;
              in_base_q     <= in_base;
              w_base_q      <= w_base;
              busy          <= 1'b1;
              bus.mac_clear <= 1'b1;
              state         <= CLEAR;
            end else begin
              result <= '0;
              done   <= 1'b1;
            end
          end
        end
        CLEAR: begin
          bus.rd_en   <= 1'b1;
          bus.in_addr <= in_base_q;
          bus.w_addr  <= w_base_q;
          cnt         <= LEN_ONE;
          state       <= STREAM;
        end
        STREAM: begin
          // cnt counts reads already issued, including the one on the bus now.
          if (cnt == len_q) begin
            bus.rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            bus.in_addr <= bus.in_addr + ADDR_ONE;
            bus.w_addr  <= bus.w_addr + ADDR_ONE;
            cnt         <= cnt + LEN_ONE;
          end
        end
        DRAIN: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          result <= bus.mac_out;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - directed bench for mac_operand_feeder with buffer and Q8.8 MAC models
module tb_mac_operand_feeder;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic [7:0]  in_base;
  logic [7:0]  w_base;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  mac_operand_feeder_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  mac_operand_feeder #(.DATA_W(16), .ADDR_W(8), .LEN_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .len     (len),
    .in_base (in_base),
    .w_base  (w_base),
    .busy    (busy),
    .result  (result),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [15:0]        in_mem [256];
  logic [15:0]        w_mem  [256];
  logic signed [15:0] acc = 16'sd0;
  logic signed [31:0] prod;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.in_rdata <= in_mem[bus.in_addr];
      bus.w_rdata  <= w_mem[bus.w_addr];
    end
  end

  // MAC lane: product rescaled to Q8.8, not touched by the feeder's reset.
  assign prod = $signed(bus.mac_in_data) * $signed(bus.mac_weight);
  always @(posedge clk) begin
    if (bus.mac_clear) acc <= 16'sd0;
    else if (bus.mac_enable) acc <= acc + $signed(prod[23:8]);
  end
  assign bus.mac_out = acc;

  int         done_cyc, rd_first, rd_last, rd_cnt, en_first, en_last, clr_cnt;
  logic       busy1, busy_done;
  logic [7:0] ia_seq[$];
  logic [7:0] wa_seq[$];

  task automatic run_job(input logic [7:0] l, input logic [7:0] ib, input logic [7:0] wb);
    done_cyc = -1; rd_first = -1; rd_last = -1; rd_cnt = 0;
    en_first = -1; en_last = -1; clr_cnt = 0; busy1 = 1'b0; busy_done = 1'b1;
    ia_seq.delete(); wa_seq.delete();
    @(negedge clk);
    start = 1'b1; len = l; in_base = ib; w_base = wb;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.rd_en) begin
        if (rd_first < 0) rd_first = c;
        rd_last = c;
        rd_cnt++;
        ia_seq.push_back(bus.in_addr);
        wa_seq.push_back(bus.w_addr);
      end
      if (bus.mac_enable) begin
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (bus.mac_clear) clr_cnt++;
      if (c == 1) busy1 = busy;
      if (done) begin
        done_cyc  = c;
        busy_done = busy;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL job_timeout: no done within 40 cycles (len=%0d)", l);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; len = '0; in_base = '0; w_base = '0;
    for (int i = 0; i < 256; i++) begin
      in_mem[i] = 16'h0000;
      w_mem[i]  = 16'h0000;
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, result, bus.rd_en, bus.in_addr, bus.w_addr, bus.mac_clear, bus.mac_enable} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h rd_en=%b in_addr=%h w_addr=%h clr=%b en=%b, required all 0",
               busy, done, result, bus.rd_en, bus.in_addr, bus.w_addr, bus.mac_clear, bus.mac_enable);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    in_mem[8'h00] = 16'h0100; in_mem[8'h01] = 16'h0180;
    w_mem[8'h10]  = 16'h0200; w_mem[8'h11]  = 16'h0080;
    run_job(8'd2, 8'h00, 8'h10);
    checks++; if (rd_first !== 2 || rd_last !== 3) begin errors++;
      $display("FAIL basic_rd_window: cycles %0d..%0d, required 2..3", rd_first, rd_last); end
    checks++; if (en_first !== 3 || en_last !== 4) begin errors++;
      $display("FAIL basic_en_window: cycles %0d..%0d, required 3..4", en_first, en_last); end
    checks++; if (done_cyc !== 6) begin errors++;
      $display("FAIL basic_done_cycle: %0d, required 6", done_cyc); end
    checks++; if (result !== 16'h02C0) begin errors++;
      $display("FAIL basic_result: %h, required 02c0", result); end
    checks++; if (busy1 !== 1'b1 || busy_done !== 1'b0) begin errors++;
      $display("FAIL basic_busy: cycle1=%b done_cycle=%b, required 1 0", busy1, busy_done); end
    checks++; if (clr_cnt !== 1) begin errors++;
      $display("FAIL basic_clear_count: %0d, required 1", clr_cnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || result !== 16'h02C0) begin errors++;
      $display("FAIL basic_hold: done=%b result=%h, required 0 02c0", done, result); end
  endtask

  task automatic test_negative();
    in_mem[8'h40] = 16'hFF00;
    w_mem[8'h50]  = 16'h0300;
    run_job(8'd1, 8'h40, 8'h50);
    checks++; if (done_cyc !== 5) begin errors++;
      $display("FAIL neg_done_cycle: %0d, required 5", done_cyc); end
    checks++; if (result !== 16'hFD00) begin errors++;
      $display("FAIL neg_result: %h, required fd00", result); end
  endtask

  task automatic test_zero_len();
    run_job(8'd0, 8'h00, 8'h00);
    checks++; if (rd_cnt !== 0 || clr_cnt !== 0) begin errors++;
      $display("FAIL zero_no_activity: reads=%0d clears=%0d, required 0 0", rd_cnt, clr_cnt); end
    checks++; if (done_cyc !== 1) begin errors++;
      $display("FAIL zero_done_cycle: %0d, required 1", done_cyc); end
    checks++; if (result !== 16'h0000 || busy1 !== 1'b0) begin errors++;
      $display("FAIL zero_result_busy: result=%h busy=%b, required 0000 0", result, busy1); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_i [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] exp_w [4] = '{8'hFF, 8'h00, 8'h01, 8'h02};
    run_job(8'd4, 8'hFE, 8'hFF);
    checks++;
    if (ia_seq.size() != 4 || wa_seq.size() != 4) begin
      errors++;
      $display("FAIL wrap_read_count: in=%0d w=%0d, required 4 4", ia_seq.size(), wa_seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ia_seq[i] !== exp_i[i] || wa_seq[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL wrap_addr[%0d]: in=%h w=%h, required %h %h", i, ia_seq[i], wa_seq[i], exp_i[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    dc = -1;
    @(negedge clk);
    start = 1'b1; len = 8'd2; in_base = 8'h00; w_base = 8'h10;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 2) begin start = 1'b1; len = 8'd5; in_base = 8'h40; w_base = 8'h50; end
      if (c == 3) start = 1'b0;
      if (done) begin dc = c; break; end
      @(negedge clk);
    end
    checks++; if (dc !== 6 || result !== 16'h02C0) begin errors++;
      $display("FAIL ignore_start: done_cycle=%0d result=%h, required 6 02c0", dc, result); end
    start = 1'b1; len = 8'd1; in_base = 8'h40; w_base = 8'h50;
    @(negedge clk);
    start = 1'b0;
    checks++; if (bus.mac_clear !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL start_in_done_cycle: clear=%b busy=%b, required 1 1", bus.mac_clear, busy); end
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin dc = c; break; end
      @(negedge clk);
    end
    checks++; if (dc !== 5 || result !== 16'hFD00) begin errors++;
      $display("FAIL second_job: done_cycle=%0d result=%h, required 5 fd00", dc, result); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      in_mem[8'h20 + i] = 16'h0100;
      w_mem[8'h30 + i]  = 16'h0100;
    end
    @(negedge clk);
    start = 1'b1; len = 8'd8; in_base = 8'h20; w_base = 8'h30;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.rd_en !== 1'b1) begin errors++;
      $display("FAIL mid_streaming: rd_en=%b, required 1", bus.rd_en); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, bus.rd_en, bus.in_addr, bus.w_addr, bus.mac_clear, bus.mac_enable} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b result=%h rd_en=%b in_addr=%h w_addr=%h clr=%b en=%b, required all 0",
               busy, done, result, bus.rd_en, bus.in_addr, bus.w_addr, bus.mac_clear, bus.mac_enable);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.rd_en !== 1'b0) begin errors++;
      $display("FAIL idle_after_abort: busy=%b rd_en=%b, required 0 0", busy, bus.rd_en); end
    run_job(8'd2, 8'h00, 8'h10);
    checks++; if (done_cyc !== 6 || result !== 16'h02C0) begin errors++;
      $display("FAIL job_after_abort: done_cycle=%0d result=%h, required 6 02c0", done_cyc, result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_zero_len();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
